// File: rtl/ghoul_pkg.sv
// Shared types and constants for the ghoul swarm: state encoding, screen bounds, spawn layout, colours.
package ghoul_pkg;

    typedef enum logic [1:0] {ALIVE, FLASH, DEAD} ghoul_state_e;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned X_MIN     = 0;
    localparam int unsigned X_MAX     = SCREEN_W - 1;
    localparam int unsigned Y_MIN     = 0;
    localparam int unsigned Y_MAX     = SCREEN_H - 1;
    localparam int unsigned X_START   = 100;
    localparam int unsigned X_SPACING = 100;
    localparam int unsigned Y_START   = 150;
    localparam int unsigned X_W       = 10;
    localparam int unsigned Y_W       = 9;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_ALIVE = '{r: 8'h60, g: 8'hA0, b: 8'h60};
    localparam rgb_t COL_FLASH = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb_t COL_NONE  = '{r: 8'h00, g: 8'h00, b: 8'h00};

endpackage

// File: rtl/ghoul_if.sv
// Bullet/pixel inputs and event/colour outputs between the swarm and the game fabric.
interface ghoul_if
    import ghoul_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) ();
    logic             enable;
    logic [X_W-1:0]   bullet_x;
    logic [Y_W-1:0]   bullet_y;
    logic             bullet_active;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             bullet_hit;
    logic             kill_pulse;
    logic [CNT_W-1:0] alive_count;
    logic             ghoul_pix;
    logic [7:0]       ghoul_r;
    logic [7:0]       ghoul_g;
    logic [7:0]       ghoul_b;

    modport master (
        output enable, bullet_x, bullet_y, bullet_active, x, y,
        input  bullet_hit, kill_pulse, alive_count, ghoul_pix, ghoul_r, ghoul_g, ghoul_b
    );

    modport slave (
        input  enable, bullet_x, bullet_y, bullet_active, x, y,
        output bullet_hit, kill_pulse, alive_count, ghoul_pix, ghoul_r, ghoul_g, ghoul_b
    );
endinterface

// File: rtl/ghoul_unit.sv
// One ghoul: state FSM, health, flash/respawn timer, bouncing position, hit-box and sprite flags.
module ghoul_unit
    import ghoul_pkg::*;
#(
    parameter int unsigned IDX           = 0,
    parameter int unsigned GHOUL_WIDTH   = 16,
    parameter int unsigned GHOUL_HEIGHT  = 16,
    parameter int unsigned MAX_HEALTH    = 3,
    parameter int unsigned FLASH_TICKS   = 4,
    parameter int unsigned RESPAWN_TICKS = 64,
    parameter int unsigned SPAWN_X       = 100,
    parameter int unsigned SPAWN_Y       = 150
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           tick_i,
    input  logic           hit_i,
    input  logic [X_W-1:0] bullet_x_i,
    input  logic [Y_W-1:0] bullet_y_i,
    input  logic [X_W-1:0] x_i,
    input  logic [Y_W-1:0] y_i,
    output logic           hittable_c,
    output logic           kill_c,
    output logic           pix_c,
    output logic           flash_c,
    output logic           live_c
);
    localparam int unsigned HW   = $clog2(MAX_HEALTH + 1);
    localparam int unsigned TMAX = (FLASH_TICKS > RESPAWN_TICKS) ? FLASH_TICKS : RESPAWN_TICKS;
    localparam int unsigned TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
    localparam logic        DY0_NEG = 1'(IDX % 2);
    localparam logic signed [11:0] X_LO = 12'(X_MIN);
    localparam logic signed [11:0] X_HI = 12'(X_MAX - GHOUL_WIDTH + 1);
    localparam logic signed [11:0] Y_LO = 12'(Y_MIN);
    localparam logic signed [11:0] Y_HI = 12'(Y_MAX - GHOUL_HEIGHT + 1);

    ghoul_state_e    state_q, state_d;
    logic [HW-1:0]   health_q, health_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [X_W-1:0]  gx_q, gx_d;
    logic [Y_W-1:0]  gy_q, gy_d;
    logic            dxn_q, dxn_d, dyn_q, dyn_d;
    logic signed [11:0] nx_c, ny_c;
    logic            bul_in_c, pix_in_c;

    // Inclusive sprite boxes against the registered position
    assign bul_in_c = ({1'b0, bullet_x_i} >= {1'b0, gx_q}) &&
                      ({1'b0, bullet_x_i} <= {1'b0, gx_q} + 11'(GHOUL_WIDTH - 1)) &&
                      ({1'b0, bullet_y_i} >= {1'b0, gy_q}) &&
                      ({1'b0, bullet_y_i} <= {1'b0, gy_q} + 10'(GHOUL_HEIGHT - 1));
    assign pix_in_c = ({1'b0, x_i} >= {1'b0, gx_q}) &&
                      ({1'b0, x_i} <= {1'b0, gx_q} + 11'(GHOUL_WIDTH - 1)) &&
                      ({1'b0, y_i} >= {1'b0, gy_q}) &&
                      ({1'b0, y_i} <= {1'b0, gy_q} + 10'(GHOUL_HEIGHT - 1));

    assign hittable_c = (state_q == ALIVE) && bul_in_c;
    assign kill_c     = hit_i && (state_q == ALIVE) && (health_q <= HW'(1));
    assign pix_c      = (state_q != DEAD) && pix_in_c;
    assign flash_c    = (state_q == FLASH);
    assign live_c     = (state_q != DEAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ALIVE;
            health_q <= HW'(MAX_HEALTH);
            timer_q  <= '0;
            gx_q     <= X_W'(SPAWN_X);
            gy_q     <= Y_W'(SPAWN_Y);
            dxn_q    <= 1'b0;
            dyn_q    <= DY0_NEG;
        end else begin
            state_q  <= state_d;
            health_q <= health_d;
            timer_q  <= timer_d;
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            dxn_q    <= dxn_d;
            dyn_q    <= dyn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        health_d = health_q;
        timer_d  = timer_q;
        gx_d     = gx_q;
        gy_d     = gy_q;
        dxn_d    = dxn_q;
        dyn_d    = dyn_q;
        nx_c     = $signed({2'b00, gx_q}) + (dxn_q ? -12'sd1 : 12'sd1);
        ny_c     = $signed({3'b000, gy_q}) + (dyn_q ? -12'sd1 : 12'sd1);

        // A step that would leave the arena reverses direction and holds position for this tick
        if (tick_i && (state_q != DEAD)) begin
            if ((nx_c < X_LO) || (nx_c > X_HI)) dxn_d = ~dxn_q;
            else                                gx_d  = X_W'(nx_c);
            if ((ny_c < Y_LO) || (ny_c > Y_HI)) dyn_d = ~dyn_q;
            else                                gy_d  = Y_W'(ny_c);
        end

        case (state_q)
            ALIVE: begin
                if (hit_i) begin
                    if (health_q > HW'(1)) begin
                        state_d  = FLASH;
                        health_d = health_q - HW'(1);
                        timer_d  = TW'(FLASH_TICKS);
                    end else begin
                        state_d  = DEAD;
                        health_d = '0;
                        timer_d  = TW'(RESPAWN_TICKS);
                    end
                end
            end
            FLASH: begin
                if (tick_i) begin
                    if (timer_q <= TW'(1)) state_d = ALIVE;
                    else                   timer_d = timer_q - TW'(1);
                end
            end
            DEAD: begin
                if ((RESPAWN_TICKS != 0) && tick_i) begin
                    if (timer_q <= TW'(1)) begin
                        state_d  = ALIVE;
                        health_d = HW'(MAX_HEALTH);
                        gx_d     = X_W'(SPAWN_X);
                        gy_d     = Y_W'(SPAWN_Y);
                        dxn_d    = 1'b0;
                        dyn_d    = DY0_NEG;
                    end else begin
                        timer_d  = timer_q - TW'(1);
                    end
                end
            end
            default: state_d = ALIVE;
        endcase
    end

endmodule

// File: rtl/ghoul_swarm.sv
// Enemy manager top: move-tick divider, lowest-index hit arbitration, one-hit-per-bullet lock,
// event pulses, alive counter and priority sprite render.
module ghoul_swarm
    import ghoul_pkg::*;
#(
    parameter int unsigned NUM_GHOULS    = 3,
    parameter int unsigned GHOUL_WIDTH   = 16,
    parameter int unsigned GHOUL_HEIGHT  = 16,
    parameter int unsigned MAX_HEALTH    = 3,
    parameter int unsigned MOVE_DIV      = 500000,
    parameter int unsigned FLASH_TICKS   = 4,
    parameter int unsigned RESPAWN_TICKS = 64,
    parameter int unsigned SPAWN_X0      = X_START,
    parameter int unsigned SPAWN_DX      = X_SPACING,
    parameter int unsigned SPAWN_Y       = Y_START
) (
    input  logic clk,
    input  logic reset_n,
    ghoul_if.slave bus
);
    localparam int unsigned CW = $clog2(NUM_GHOULS + 1);
    localparam int unsigned DW = $clog2(MOVE_DIV);

    logic [DW-1:0]         div_q, div_d;
    logic                  hit_lock_q, hit_lock_d;
    logic                  bullet_hit_q, kill_pulse_q;
    logic [CW-1:0]         alive_count_q, alive_cnt_c;
    logic                  tick_c, qualify_c, found_c;
    logic [NUM_GHOULS-1:0] hittable_c, hit_c, kill_c, pix_c, flash_c, live_c;
    rgb_t                  col_c;
    logic                  any_pix_c;

    assign tick_c    = bus.enable && (div_q == DW'(MOVE_DIV - 1));
    assign qualify_c = bus.enable && bus.bullet_active && !hit_lock_q;

    for (genvar gi = 0; gi < NUM_GHOULS; gi++) begin : g_ghoul
        ghoul_unit #(
            .IDX           (gi),
            .GHOUL_WIDTH   (GHOUL_WIDTH),
            .GHOUL_HEIGHT  (GHOUL_HEIGHT),
            .MAX_HEALTH    (MAX_HEALTH),
            .FLASH_TICKS   (FLASH_TICKS),
            .RESPAWN_TICKS (RESPAWN_TICKS),
            .SPAWN_X       (SPAWN_X0 + gi * SPAWN_DX),
            .SPAWN_Y       (SPAWN_Y)
        ) u_ghoul (
            .clk        (clk),
            .reset_n    (reset_n),
            .tick_i     (tick_c),
            .hit_i      (hit_c[gi]),
            .bullet_x_i (bus.bullet_x),
            .bullet_y_i (bus.bullet_y),
            .x_i        (bus.x),
            .y_i        (bus.y),
            .hittable_c (hittable_c[gi]),
            .kill_c     (kill_c[gi]),
            .pix_c      (pix_c[gi]),
            .flash_c    (flash_c[gi]),
            .live_c     (live_c[gi])
        );
    end

    // Lowest-index hittable ghoul takes the bullet; the lock holds until the bullet retires
    always_comb begin
        hit_c   = '0;
        found_c = 1'b0;
        for (int i = 0; i < NUM_GHOULS; i++) begin
            if (!found_c && qualify_c && hittable_c[i]) begin
                hit_c[i] = 1'b1;
                found_c  = 1'b1;
            end
        end
        if (!bus.bullet_active) hit_lock_d = 1'b0;
        else if (found_c)       hit_lock_d = 1'b1;
        else                    hit_lock_d = hit_lock_q;
        div_d = div_q;
        if (bus.enable) div_d = tick_c ? '0 : div_q + DW'(1);
        alive_cnt_c = '0;
        for (int i = 0; i < NUM_GHOULS; i++) alive_cnt_c = alive_cnt_c + CW'(live_c[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= '0;
            hit_lock_q    <= 1'b0;
            bullet_hit_q  <= 1'b0;
            kill_pulse_q  <= 1'b0;
            alive_count_q <= CW'(NUM_GHOULS);
        end else begin
            div_q         <= div_d;
            hit_lock_q    <= hit_lock_d;
            bullet_hit_q  <= found_c;
            kill_pulse_q  <= |kill_c;
            alive_count_q <= alive_cnt_c;
        end
    end

    // Walk from the highest index down so the lowest visible ghoul owns the pixel
    always_comb begin
        any_pix_c = 1'b0;
        col_c     = COL_NONE;
        for (int i = NUM_GHOULS - 1; i >= 0; i--) begin
            if (pix_c[i]) begin
                any_pix_c = 1'b1;
                col_c     = flash_c[i] ? COL_FLASH : COL_ALIVE;
            end
        end
    end

    assign bus.bullet_hit  = bullet_hit_q;
    assign bus.kill_pulse  = kill_pulse_q;
    assign bus.alive_count = alive_count_q;
    assign bus.ghoul_pix   = any_pix_c;
    assign bus.ghoul_r     = col_c.r;
    assign bus.ghoul_g     = col_c.g;
    assign bus.ghoul_b     = col_c.b;

endmodule

// File: tb/tb_ghoul_swarm.sv
// Directed bench for ghoul_swarm: default layout (dut_a) plus a right-edge layout (dut_b)
// for overlap priority and wall bounce.
module tb_ghoul_swarm;
    logic clk;
    logic rst_a, rst_b;
    int   errors = 0;
    int   checks = 0;
    int   ecnt   = 0;
    int   pulses;

    ghoul_if #(.CNT_W(2)) a_if ();
    ghoul_if #(.CNT_W(2)) b_if ();

    ghoul_swarm #(.NUM_GHOULS(3), .MOVE_DIV(4), .FLASH_TICKS(2), .RESPAWN_TICKS(3)) dut_a (
        .clk(clk), .reset_n(rst_a), .bus(a_if)
    );
    ghoul_swarm #(.NUM_GHOULS(3), .MOVE_DIV(4), .FLASH_TICKS(2), .RESPAWN_TICKS(3),
                  .SPAWN_X0(608), .SPAWN_DX(8), .SPAWN_Y(150)) dut_b (
        .clk(clk), .reset_n(rst_b), .bus(b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         px;
        int         py;
        int         col;   // 0 none, 1 alive green, 2 flash white
        string      nm;
    } pix_vec_t;

    function automatic logic [24:0] exp_rgb(input int col);
        case (col)
            0:       return 25'h0;
            1:       return {1'b1, 8'h60, 8'hA0, 8'h60};
            default: return {1'b1, 8'hFF, 8'hFF, 8'hFF};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_pix(input string nm, input bit sel_b, input int px, input int py, input int col);
        logic [24:0] act;
        if (sel_b) begin b_if.x = 10'(px); b_if.y = 9'(py); end
        else       begin a_if.x = 10'(px); a_if.y = 9'(py); end
        #1;
        act = sel_b ? {b_if.ghoul_pix, b_if.ghoul_r, b_if.ghoul_g, b_if.ghoul_b}
                    : {a_if.ghoul_pix, a_if.ghoul_r, a_if.ghoul_g, a_if.ghoul_b};
        chk(nm, 32'(act), 32'(exp_rgb(col)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic run_to(input int n);
        while (ecnt < n) step();
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        a_if.enable = 1'b1;
        a_if.bullet_active = 1'b0;
        step();
        rst_a = 1'b1;
        ecnt = 0;
    endtask

    // Three separate bullets on ghoul0; the third kills it (returns just after that edge)
    task automatic kill_g0(input string nm);
        reset_a();
        a_if.bullet_x = 10'd108; a_if.bullet_y = 9'd158;
        step(); a_if.bullet_active = 1'b1;
        step();
        chk({nm, "_hit1"}, 32'(a_if.bullet_hit), 32'd1);
        chk({nm, "_nokill1"}, 32'(a_if.kill_pulse), 32'd0);
        a_if.bullet_active = 1'b0;
        run_to(8); a_if.bullet_active = 1'b1;
        step();
        chk({nm, "_hit2"}, 32'(a_if.bullet_hit), 32'd1);
        chk({nm, "_nokill2"}, 32'(a_if.kill_pulse), 32'd0);
        a_if.bullet_active = 1'b0;
        run_to(16); a_if.bullet_active = 1'b1;
        step();
        chk({nm, "_hit3"}, 32'(a_if.bullet_hit), 32'd1);
        chk({nm, "_kill3"}, 32'(a_if.kill_pulse), 32'd1);
        chk({nm, "_cnt_lag"}, 32'(a_if.alive_count), 32'd3);
        a_if.bullet_active = 1'b0;
    endtask

    pix_vec_t tbl[9];

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        a_if.enable = 1'b0; a_if.bullet_active = 1'b0; a_if.bullet_x = '0; a_if.bullet_y = '0;
        a_if.x = '0; a_if.y = '0;
        b_if.enable = 1'b0; b_if.bullet_active = 1'b0; b_if.bullet_x = '0; b_if.bullet_y = '0;
        b_if.x = '0; b_if.y = '0;

        tbl[0] = '{100, 150, 1, "g0_tl"};
        tbl[1] = '{115, 165, 1, "g0_br"};
        tbl[2] = '{116, 150, 0, "g0_right"};
        tbl[3] = '{99,  150, 0, "g0_left"};
        tbl[4] = '{100, 166, 0, "g0_below"};
        tbl[5] = '{200, 150, 1, "g1_tl"};
        tbl[6] = '{315, 165, 1, "g2_br"};
        tbl[7] = '{316, 165, 0, "g2_right"};
        tbl[8] = '{250, 200, 0, "empty"};
        #12;

        // Reset state and render
        chk("rst_alive", 32'(a_if.alive_count), 32'd3);
        chk("rst_hit", 32'(a_if.bullet_hit), 32'd0);
        chk("rst_kill", 32'(a_if.kill_pulse), 32'd0);
        foreach (tbl[i]) chk_pix(tbl[i].nm, 1'b0, tbl[i].px, tbl[i].py, tbl[i].col);

        // Held bullet: exactly one hit, flash for two ticks
        reset_a();
        a_if.bullet_x = 10'd105; a_if.bullet_y = 9'd155;
        step(); a_if.bullet_active = 1'b1;
        step();
        chk("t2_hit", 32'(a_if.bullet_hit), 32'd1);
        chk_pix("t2_white", 1'b0, 105, 155, 2);
        pulses = 1;
        while (ecnt < 12) begin
            step();
            pulses += 32'(a_if.bullet_hit);
            if (ecnt == 7) chk_pix("t2_still_flash", 1'b0, 105, 155, 2);
            if (ecnt == 8) chk_pix("t2_alive_again", 1'b0, 105, 155, 1);
        end
        chk("t2_one_pulse", 32'(pulses), 32'd1);
        a_if.bullet_active = 1'b0;

        // Kill, invisibility, alive_count and respawn
        kill_g0("t3");
        step();
        chk("t3_kill_1cyc", 32'(a_if.kill_pulse), 32'd0);
        chk("t3_alive2", 32'(a_if.alive_count), 32'd2);
        chk_pix("t3_invisible", 1'b0, 106, 156, 0);
        run_to(27);
        chk_pix("t3_not_yet", 1'b0, 100, 150, 0);
        chk("t3_alive2b", 32'(a_if.alive_count), 32'd2);
        step();
        chk_pix("t3_respawn", 1'b0, 100, 150, 1);
        chk_pix("t3_respawn_edge", 1'b0, 116, 150, 0);
        step();
        chk("t3_alive3", 32'(a_if.alive_count), 32'd3);

        // Overlap of ghouls 1 and 2: ghoul1 takes the hit
        rst_a = 1'b0;
        b_if.bullet_x = 10'd630; b_if.bullet_y = 9'd157;
        b_if.bullet_active = 1'b1; b_if.enable = 1'b1;
        rst_b = 1'b1; ecnt = 0;
        step();
        chk("t4_hit", 32'(b_if.bullet_hit), 32'd1);
        chk("t4_nokill", 32'(b_if.kill_pulse), 32'd0);
        chk_pix("t4_g1_flash", 1'b1, 630, 157, 2);
        chk_pix("t4_g2_alive", 1'b1, 637, 160, 1);
        b_if.bullet_active = 1'b0;
        step(); b_if.bullet_active = 1'b1;
        step();
        chk("t4_hit_g2", 32'(b_if.bullet_hit), 32'd1);
        chk_pix("t4_g2_flash", 1'b1, 637, 160, 2);
        b_if.bullet_active = 1'b0;

        // Right-wall bounce of ghoul2 spawned at 624
        rst_b = 1'b0;
        step();
        rst_b = 1'b1; ecnt = 0;
        run_to(3);
        chk_pix("t5_start", 1'b1, 639, 150, 1);
        step();
        chk_pix("t5_hold", 1'b1, 639, 151, 1);
        run_to(8);
        chk_pix("t5_left_gone", 1'b1, 639, 152, 0);
        chk_pix("t5_left_in", 1'b1, 638, 152, 1);
        run_to(12);
        chk_pix("t5_left2_gone", 1'b1, 638, 153, 0);
        chk_pix("t5_left2_in", 1'b1, 637, 153, 1);
        rst_b = 1'b0;

        // Freeze mid-flash
        reset_a();
        a_if.bullet_x = 10'd105; a_if.bullet_y = 9'd155;
        step(); a_if.bullet_active = 1'b1;
        step();
        chk("t6_hit", 32'(a_if.bullet_hit), 32'd1);
        a_if.bullet_active = 1'b0;
        run_to(5);
        a_if.enable = 1'b0;
        a_if.bullet_x = 10'd205; a_if.bullet_y = 9'd155; a_if.bullet_active = 1'b1;
        pulses = 0;
        repeat (20) begin
            step();
            pulses += 32'(a_if.bullet_hit) + 32'(a_if.kill_pulse);
        end
        chk("t6_no_events", 32'(pulses), 32'd0);
        chk_pix("t6_frozen_flash", 1'b0, 101, 151, 2);
        chk_pix("t6_frozen_pos", 1'b0, 100, 150, 0);
        a_if.bullet_active = 1'b0;
        a_if.enable = 1'b1;
        run_to(27);
        chk_pix("t6_timer_held", 1'b0, 101, 151, 2);
        step();
        chk_pix("t6_resume", 1'b0, 102, 152, 1);
        chk_pix("t6_resume_old", 1'b0, 101, 151, 0);

        // Async reset while ghoul0 is dead and pulses are high
        kill_g0("t6k");
        #2 rst_a = 1'b0;
        #1;
        chk("t6r_hit_drop", 32'(a_if.bullet_hit), 32'd0);
        chk("t6r_kill_drop", 32'(a_if.kill_pulse), 32'd0);
        chk("t6r_alive3", 32'(a_if.alive_count), 32'd3);
        chk_pix("t6r_g0_back", 1'b0, 100, 150, 1);
        kill_g0("t6h");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
